// File: rtl/square_share_if.sv
// ---------------------------------------------------------------------------
// square_share_if
// Bundles the requester-side and result-side handshake of square_share.
//
//   req_valid [NREQ]    per-requester request
//   req_v     [8*NREQ]  operands, requester k in bits [8k+7:8k]
//   req_ready [NREQ]    one-hot grant/accept strobe
//   res_valid           result available
//   res_id    [3]       requester that owns the result
//   res_v2    [11]      approximate square (v*v)>>5
//   res_ready           result consumer accept
//   busy                arbiter not idle
//
// Modports: master = requesters/consumer side, slave = square_share.
// ---------------------------------------------------------------------------
interface square_share_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_v;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [2:0]        res_id;
    logic [10:0]       res_v2;
    logic              res_ready;
    logic              busy;

    modport master (
        output req_valid, req_v, res_ready,
        input  req_ready, res_valid, res_id, res_v2, busy
    );

    modport slave (
        input  req_valid, req_v, res_ready,
        output req_ready, res_valid, res_id, res_v2, busy
    );
endinterface

// File: rtl/square_share.sv
// ---------------------------------------------------------------------------
// square_share
// Round-robin arbiter that time-shares one pipelined 8-bit squarer between
// NREQ requesters. One operation is in flight at a time:
// IDLE (grant) -> CALC (LAT cycles) -> RESULT (hold until res_ready) -> IDLE.
//
// Ports:
//   clk       sole clock, posedge
//   rst       synchronous active-high reset
//   bus       square_share_if.slave (request/grant and result handshake)
//   stat_sel  [3]  (SQUARE_SHARE_STATS_EN only) counter select
//   stat_cnt  [16] (SQUARE_SHARE_STATS_EN only) grants to requester stat_sel,
//                  saturating, one cycle read latency
//
// Parameters: NREQ (2..8) requesters, LAT (1..4) squarer result stages.
// Optional feature macro: SQUARE_SHARE_STATS_EN.
// ---------------------------------------------------------------------------

// Shared squarer: LAT register stages computing (v*v)>>5 from a held operand.
module square_approx #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  v,
    output logic [10:0] sq
);
    logic [10:0] r_pipe [LAT];
    logic [10:0] w_sq_comb;

    assign w_sq_comb = 11'((16'(v) * 16'(v)) >> 5);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_sq_comb;
            for (int i = 1; i < LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign sq = r_pipe[LAT-1];
endmodule

module square_share #(
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic          clk,
    input  logic          rst,
`ifdef SQUARE_SHARE_STATS_EN
    input  logic [2:0]    stat_sel,
    output logic [15:0]   stat_cnt,
`endif
    square_share_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_next;
    logic [2:0]  r_last;
    logic [2:0]  r_id;
    logic [7:0]  r_op;

    logic [7:0]      w_vld8;
    logic [3:0]      w_idx;
    logic            w_any;
    logic [2:0]      w_win;
    logic            w_grant;
    logic [NREQ-1:0] w_gnt;
    logic [7:0]      w_op;
    logic [10:0]     w_sq;

    // Padded to 8 bits so a 3-bit index always fits the vector exactly.
    assign w_vld8 = 8'(bus.req_valid);

    // Round-robin search starting one past the last winner; the first hit
    // in rotation order wins, later hits are ignored.
    always_comb begin
        w_any = 1'b0;
        w_win = r_last;
        w_idx = '0;
        for (int d = 1; d <= NREQ; d++) begin
            w_idx = {1'b0, r_last} + 4'(d);
            if (w_idx >= 4'(NREQ)) begin
                w_idx = w_idx - 4'(NREQ);
            end
            if (!w_any && w_vld8[w_idx[2:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[2:0];
            end
        end
    end

    // Grants are suppressed while rst is high so no strobe is ever issued
    // for a request that the reset edge will throw away.
    assign w_grant = (r_state == S_IDLE) && w_any && !rst;
    assign w_gnt   = w_grant ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : '0;
    assign w_op    = 8'(bus.req_v >> {w_win, 3'b000});

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_next = S_CALC;
                    w_cnt_next   = '0;
                end
            end
            S_CALC: begin
                if (r_cnt == 3'(LAT-1)) begin
                    w_state_next = S_RESULT;
                end else begin
                    w_cnt_next = r_cnt + 3'd1;
                end
            end
            S_RESULT: begin
                if (bus.res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= 3'(NREQ-1);
            r_id    <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_grant) begin
                r_last <= w_win;
                r_id   <= w_win;
                r_op   <= w_op;
            end
        end
    end

    // r_op only changes on a grant, so the squarer output is stable for the
    // whole RESULT phase without a separate result register.
    square_approx #(
        .LAT (LAT)
    ) u_square (
        .clk (clk),
        .rst (rst),
        .v   (r_op),
        .sq  (w_sq)
    );

    assign bus.req_ready = w_gnt;
    assign bus.res_valid = (r_state == S_RESULT);
    assign bus.res_id    = r_id;
    assign bus.res_v2    = w_sq;
    assign bus.busy      = (r_state != S_IDLE);

`ifdef SQUARE_SHARE_STATS_EN
    logic [15:0] w_stat [8];
    logic [15:0] r_stat_cnt;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_stat
            if (gi < NREQ) begin : g_cnt
                logic [15:0] r_grants;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_grants <= '0;
                    end else if (w_grant && (w_win == 3'(gi)) && (r_grants != 16'hFFFF)) begin
                        r_grants <= r_grants + 16'd1;
                    end
                end
                assign w_stat[gi] = r_grants;
            end else begin : g_none
                assign w_stat[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cnt <= '0;
        end else begin
            r_stat_cnt <= w_stat[stat_sel];
        end
    end

    assign stat_cnt = r_stat_cnt;
`endif
endmodule

// File: tb/tb_square_share.sv
// ---------------------------------------------------------------------------
// tb_square_share
// Self-checking bench for square_share (NREQ=4, LAT=2). A transaction-level
// reference model (round-robin pointer, single in-flight job, arithmetic
// square) checks every cycle; directed tables and sequences cover single
// requests, grant order, result hold, reset mid-calculation and a full
// operand sweep, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_square_share;
    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst;
    always #HALF clk = ~clk;

    square_share_if #(.NREQ(NREQ)) bus ();

`ifdef SQUARE_SHARE_STATS_EN
    logic [2:0]  stat_sel;
    logic [15:0] stat_cnt;
`endif

    square_share #(
        .NREQ (NREQ),
        .LAT  (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SQUARE_SHARE_STATS_EN
        .stat_sel (stat_sel),
        .stat_cnt (stat_cnt),
`endif
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit inflight;
    int last_m;
    int pid;
    int pv;
    int g_cyc;
    int cyc;
    int txn_n;
    int gnt_log[$];

    // What the last cycle() observed
    int seen_gnt;
    bit seen_res;
    int seen_id;
    int seen_v2;

    typedef struct {
        int req;
        int v;
        int lo;
    } vec_t;

    task automatic check(string name, bit ok, int act, int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(logic [NREQ-1:0] vld, int last);
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx = (last + i) % NREQ;
            if (vld[idx] === 1'b1) return idx;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(logic [NREQ-1:0] r);
        int idx;
        int cnt;
        idx = -1;
        cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (r[i] === 1'b1) begin
                idx = i;
                cnt++;
            end
        end
        if (cnt > 1) idx = -2;
        return idx;
    endfunction

    // Called right after a falling edge with inputs already driven: checks
    // this cycle's outputs against the model, advances the model across the
    // coming rising edge, then waits for the next falling edge.
    task automatic cycle();
        int w;
        int lo;
        bit exp_rv;
        logic [NREQ-1:0] one;
        logic [NREQ-1:0] exp_rr;
        one = 1;
        #1;
        exp_rv = inflight && (cyc >= g_cyc + LAT + 1);
        w = inflight ? -1 : rr_pick(bus.req_valid, last_m);
        exp_rr = (w >= 0) ? (one << w) : '0;

        check("busy", bus.busy === inflight, int'(bus.busy), int'(inflight));
        if (!rst) check("req_ready", bus.req_ready === exp_rr, int'(bus.req_ready), int'(exp_rr));
        check("res_valid", bus.res_valid === exp_rv, int'(bus.res_valid), int'(exp_rv));
        if (exp_rv && bus.res_valid === 1'b1) begin
            lo = pv * pv / 32;
            check("res_id", bus.res_id === 3'(pid), int'(bus.res_id), pid);
            check("res_v2", (bus.res_v2 >= 11'(lo)) && (bus.res_v2 <= 11'(lo + 1)), int'(bus.res_v2), lo);
        end

        seen_gnt = rst ? -1 : onehot_idx(bus.req_ready);
        seen_res = (bus.res_valid === 1'b1);
        seen_id  = int'(bus.res_id);
        seen_v2  = int'(bus.res_v2);

        if (rst) begin
            inflight = 1'b0;
            last_m   = NREQ - 1;
        end else if (w >= 0) begin
            inflight = 1'b1;
            pid      = w;
            pv       = int'(bus.req_v[8*w +: 8]);
            g_cyc    = cyc;
            last_m   = w;
            gnt_log.push_back(seen_gnt);
        end else if (exp_rv && bus.res_ready === 1'b1) begin
            inflight = 1'b0;
            txn_n++;
            $display("txn %0d: id=%0d v=%0d res_v2=%0d", txn_n, seen_id, pv, seen_v2);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        for (int n = 0; n < 20 && inflight; n++) cycle();
        if (inflight) check("drain_timeout", 1'b0, 1, 0);
    endtask

    // One isolated request: returns granted index, result id/value and the
    // number of cycles from the grant strobe to the first res_valid.
    task automatic txn(input int k, input int v, output int gid, output int rid,
                       output int v2, output int lat);
        gid = -1; rid = -1; v2 = -1; lat = -1;
        bus.req_valid = '0;
        bus.req_valid[k] = 1'b1;
        bus.req_v[8*k +: 8] = 8'(v);
        bus.res_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (seen_gnt != -1) begin
                gid = seen_gnt;
                break;
            end
        end
        bus.req_valid = '0;
        if (gid == -1) begin
            check("grant_timeout", 1'b0, -1, k);
            return;
        end
        for (int n = 1; n <= 20; n++) begin
            cycle();
            if (seen_res) begin
                lat = n;
                rid = seen_id;
                v2  = seen_v2;
                break;
            end
        end
        if (lat < 0) check("result_timeout", 1'b0, -1, LAT + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int gid, rid, v2, lat, lo, id0, v20, pre;
        int exp_order[5];

        vecs[0] = '{0, 255, 2032};
        vecs[1] = '{1,   0,    0};
        vecs[2] = '{2,   1,    0};
        vecs[3] = '{3,   6,    1};
        vecs[4] = '{0, 128,  512};
        vecs[5] = '{1, 181, 1023};
        vecs[6] = '{2, 200, 1250};
        vecs[7] = '{3, 100,  312};
        exp_order = '{0, 1, 2, 3, 0};

        // ---- reset state
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_v = '0;
        bus.res_ready = 1'b0;
`ifdef SQUARE_SHARE_STATS_EN
        stat_sel = '0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", bus.busy === 1'b0, int'(bus.busy), 0);
        check("rst_res_valid", bus.res_valid === 1'b0, int'(bus.res_valid), 0);
        check("rst_res_id", bus.res_id === 3'd0, int'(bus.res_id), 0);
        check("rst_res_v2", bus.res_v2 === 11'd0, int'(bus.res_v2), 0);
        check("rst_req_ready", bus.req_ready === '0, int'(bus.req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        inflight = 1'b0;
        last_m = NREQ - 1;
        g_cyc = 0;
        cyc = 0;
        txn_n = 0;

        // ---- single-request table
        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].req, vecs[i].v, gid, rid, v2, lat);
            check("tbl_grant", gid == vecs[i].req, gid, vecs[i].req);
            check("tbl_res_id", rid == vecs[i].req, rid, vecs[i].req);
            check("tbl_res_v2", v2 >= vecs[i].lo && v2 <= vecs[i].lo + 1, v2, vecs[i].lo);
            check("tbl_latency", lat == LAT + 1, lat, LAT + 1);
            drain();
        end

        // ---- all four requesting continuously
        gnt_log.delete();
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        for (int n = 0; n < 200 && gnt_log.size() < 5; n++) begin
            bus.req_v = {$urandom, $urandom};
            cycle();
        end
        check("order_count", gnt_log.size() >= 5, gnt_log.size(), 5);
        for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
            check("grant_order", gnt_log[i] == exp_order[i], gnt_log[i], exp_order[i]);
        end
        drain();

        // ---- result held with res_ready low
        bus.req_valid = '1;
        bus.res_ready = 1'b0;
        seen_res = 1'b0;
        for (int n = 0; n < 20 && !seen_res; n++) cycle();
        check("hold_reached", seen_res, int'(seen_res), 1);
        id0 = seen_id;
        v20 = seen_v2;
        check("hold_id", id0 == 1, id0, 1);
        for (int n = 0; n < 10; n++) begin
            bus.req_v = {$urandom, $urandom};
            cycle();
            check("hold_id_stable", seen_id == id0, seen_id, id0);
            check("hold_v2_stable", seen_v2 == v20, seen_v2, v20);
            check("hold_no_grant", seen_gnt == -1, seen_gnt, -1);
        end
        bus.res_ready = 1'b1;
        cycle();
        cycle();
        check("release_grant", seen_gnt == (id0 + 1) % NREQ, seen_gnt, (id0 + 1) % NREQ);
        drain();

        // ---- reset during CALC
        bus.req_valid = '0;
        bus.req_valid[2] = 1'b1;
        bus.req_v[23:16] = 8'd77;
        pre = -1;
        for (int n = 0; n < 20 && pre == -1; n++) begin
            cycle();
            pre = seen_gnt;
        end
        check("calc_grant", pre == 2, pre, 2);
        bus.req_valid = '0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            cycle();
            check("no_res_after_rst", !seen_res, int'(seen_res), 0);
        end
        bus.req_valid = '1;
        cycle();
        check("post_rst_grant0", seen_gnt == 0, seen_gnt, 0);
        drain();

        // ---- operand sweep through every requester
        for (int k = 0; k < NREQ; k++) begin
            for (int v = 0; v < 256; v++) begin
                txn(k, v, gid, rid, v2, lat);
                lo = v * v / 32;
                check("sweep_grant", gid == k, gid, k);
                check("sweep_v2", v2 >= lo && v2 <= lo + 1, v2, lo);
                drain();
            end
        end

        // ---- randomized traffic, occasional reset
        for (int n = 0; n < 1500; n++) begin
            bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            bus.req_v = {$urandom, $urandom};
            bus.res_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        drain();

`ifdef SQUARE_SHARE_STATS_EN
        // ---- grant statistics
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            txn(2, 10 * i, gid, rid, v2, lat);
            drain();
        end
        for (int s = 0; s < NREQ; s++) begin
            stat_sel = 3'(s);
            cycle();
            cycle();
            check("stat_cnt", int'(stat_cnt) == ((s == 2) ? 5 : 0), int'(stat_cnt), (s == 2) ? 5 : 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
